// File: rtl/captura_jogada_if.sv
// captura_jogada_if: move-capture handshake between the game control unit and
// the capture block, plus the raw board buttons and the debug state code.
//   zeraEdge     control -> capture  synchronous clear
//   jogar_macro  control -> capture  request a macro-board move
//   jogar_micro  control -> capture  request a micro-board move
//   botoes[8:0]  board   -> capture  raw asynchronous position buttons
//   tem_jogada   capture -> control  one-cycle "move accepted" pulse
//   jogada[3:0]  capture -> control  encoded accepted cell 0..8
//   db_estado    capture -> debug    current FSM state code
interface captura_jogada_if;
  logic       zeraEdge;
  logic       jogar_macro;
  logic       jogar_micro;
  logic [8:0] botoes;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic [3:0] db_estado;

  // Control-unit side (also drives the board buttons in a bench).
  modport master (
    output zeraEdge,
    output jogar_macro,
    output jogar_micro,
    output botoes,
    input  tem_jogada,
    input  jogada,
    input  db_estado
  );

  // Capture-block side.
  modport slave (
    input  zeraEdge,
    input  jogar_macro,
    input  jogar_micro,
    input  botoes,
    output tem_jogada,
    output jogada,
    output db_estado
  );
endinterface

// File: rtl/captura_jogada.sv
// captura_jogada: synchronizes and debounces the nine position buttons while a
// macro or micro move is requested, accepts exactly one pressed button, and
// emits a one-cycle tem_jogada pulse with the encoded cell on jogada.
//   clock   system clock, rising edge
//   reset   asynchronous active-high reset
//   bus     captura_jogada_if.slave: zeraEdge, jogar_macro, jogar_micro,
//           botoes in; tem_jogada, jogada, db_estado out
module captura_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4  // legal range 1..255
) (
  input  logic            clock,
  input  logic            reset,
  captura_jogada_if.slave bus
);

  typedef enum logic [3:0] {
    Ocioso       = 4'd0,
    AguardaSolta = 4'd1,
    EsperaBotao  = 4'd2,
    Filtra       = 4'd3,
    Registra     = 4'd4
  } state_t;

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  state_t     r_state;
  logic [8:0] r_sync1;
  logic [8:0] r_sync2;
  logic [8:0] r_cand;
  logic [7:0] r_cnt;
  logic [3:0] r_jogada;
  logic       r_tem;

  logic w_habilita;
  logic w_onehot;

  assign w_habilita = bus.jogar_macro | bus.jogar_micro;
  assign w_onehot   = (r_sync2 != 9'd0) && ((r_sync2 & (r_sync2 - 9'd1)) == 9'd0);

  function automatic logic [3:0] encode(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= Ocioso;
      r_sync1  <= 9'd0;
      r_sync2  <= 9'd0;
      r_cand   <= 9'd0;
      r_cnt    <= 8'd0;
      r_jogada <= 4'd0;
      r_tem    <= 1'b0;
    end else begin
      // Synchronizer keeps running through zeraEdge.
      r_sync1 <= bus.botoes;
      r_sync2 <= r_sync1;
      r_tem   <= 1'b0;
      if (bus.zeraEdge) begin
        r_state  <= Ocioso;
        r_cand   <= 9'd0;
        r_cnt    <= 8'd0;
        r_jogada <= 4'd0;
      end else begin
        case (r_state)
          Ocioso: begin
            if (w_habilita) r_state <= AguardaSolta;
          end
          // A button still held from the previous move must be released first.
          AguardaSolta: begin
            if (!w_habilita)           r_state <= Ocioso;
            else if (r_sync2 == 9'd0)  r_state <= EsperaBotao;
          end
          EsperaBotao: begin
            if (!w_habilita) begin
              r_state <= Ocioso;
            end else if (w_onehot) begin
              r_state <= Filtra;
              r_cand  <= r_sync2;
              r_cnt   <= 8'd0;
            end
          end
          Filtra: begin
            if (!w_habilita) begin
              r_state <= Ocioso;
            end else if (r_sync2 != r_cand) begin
              r_state <= EsperaBotao;
            end else if (r_cnt == CntLast) begin
              r_state  <= Registra;
              r_jogada <= encode(r_cand);
              r_tem    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          // Enable is ignored here: the control unit drops it next cycle.
          Registra: r_state <= Ocioso;
          default:  r_state <= Ocioso;
        endcase
      end
    end
  end

  assign bus.tem_jogada = r_tem;
  assign bus.jogada     = r_jogada;
  assign bus.db_estado  = r_state;

endmodule

// File: tb/tb_captura_jogada.sv
module tb_captura_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zera = 1'b0;
  logic       jogar_macro = 1'b0;
  logic       jogar_micro = 1'b0;
  logic [8:0] botoes = 9'd0;

  int checks = 0;
  int failures = 0;
  int pulses4 = 0;
  int pulses1 = 0;

  always #5 clock = ~clock;

  captura_jogada_if if4 ();
  captura_jogada_if if1 ();

  assign if4.zeraEdge    = zera;
  assign if4.jogar_macro = jogar_macro;
  assign if4.jogar_micro = jogar_micro;
  assign if4.botoes      = botoes;
  assign if1.zeraEdge    = zera;
  assign if1.jogar_macro = jogar_macro;
  assign if1.jogar_micro = jogar_micro;
  assign if1.botoes      = botoes;

  captura_jogada #(.DEBOUNCE_CYCLES(4)) u_dut4 (.clock(clock), .reset(reset), .bus(if4));
  captura_jogada #(.DEBOUNCE_CYCLES(1)) u_dut1 (.clock(clock), .reset(reset), .bus(if1));

  // Behavioural model: a 2-cycle delay line for the buttons, then per instance
  // "active" (enable seen), "armed" (all-zero buttons seen), and the length of
  // the current run of one identical one-hot reading.
  int         n_db [2] = '{4, 1};
  bit         m_act [2];
  bit         m_armed [2];
  bit         m_pulse [2];
  int         m_run [2];
  logic [8:0] m_cand [2];
  logic [3:0] m_jog [2];
  logic [8:0] m_d1, m_d2;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_armed[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
      m_cand[i] = 9'd0; m_jog[i] = 4'd0;
    end
    m_d1 = 9'd0;
    m_d2 = 9'd0;
  endtask

  function automatic logic [3:0] bit_index(input logic [8:0] v);
    for (int b = 0; b < 9; b++) if (v[b]) return 4'(b);
    return 4'd0;
  endfunction

  task automatic model_step();
    logic [8:0] bs;
    bit h;
    bs = m_d2;
    m_d2 = m_d1;
    m_d1 = botoes;
    h = jogar_macro | jogar_micro;
    for (int i = 0; i < 2; i++) begin
      if (zera) begin
        m_act[i] = 0; m_armed[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
        m_cand[i] = 9'd0; m_jog[i] = 4'd0;
      end else if (m_pulse[i]) begin
        m_pulse[i] = 0; m_act[i] = 0; m_armed[i] = 0; m_run[i] = 0;
      end else if (!m_act[i]) begin
        m_act[i] = h;
      end else if (!h) begin
        m_act[i] = 0; m_armed[i] = 0; m_run[i] = 0;
      end else if (!m_armed[i]) begin
        m_armed[i] = (bs == 9'd0);
      end else if (m_run[i] == 0) begin
        if ($countones(bs) == 1) begin
          m_run[i] = 1;
          m_cand[i] = bs;
        end
      end else if (bs != m_cand[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] == n_db[i]) begin
        m_pulse[i] = 1;
        m_jog[i] = bit_index(m_cand[i]);
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
    end
  endtask

  function automatic int model_db(input int i);
    if (m_pulse[i]) return 4;
    if (!m_act[i]) return 0;
    if (!m_armed[i]) return 1;
    if (m_run[i] == 0) return 2;
    return 3;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      chk("tem4", int'(if4.tem_jogada), int'(m_pulse[0]));
      chk("jog4", int'(if4.jogada), int'(m_jog[0]));
      chk("db4", int'(if4.db_estado), model_db(0));
      chk("tem1", int'(if1.tem_jogada), int'(m_pulse[1]));
      chk("jog1", int'(if1.jogada), int'(m_jog[1]));
      chk("db1", int'(if1.db_estado), model_db(1));
      if (if4.tem_jogada) pulses4++;
      if (if1.tem_jogada) pulses1++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  int exp_seq [8] = '{1, 2, 3, 3, 3, 3, 4, 0};
  int seq [8];
  int lat4, lat1, p4, p1;
  logic [8:0] oh;

  initial begin
    #1 reset = 1'b1;
    tick(2);
    chk("rst_tem", int'(if4.tem_jogada), 0);
    chk("rst_jog", int'(if4.jogada), 0);
    chk("rst_db", int'(if4.db_estado), 0);
    reset = 1'b0;
    tick(3);

    // Macro move, button 4 pressed together with the request.
    jogar_macro = 1'b1;
    botoes = 9'b000010000;
    lat4 = -1;
    lat1 = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 8) seq[i] = int'(if4.db_estado);
      if (if4.tem_jogada && lat4 < 0) lat4 = i;
      if (if1.tem_jogada && lat1 < 0) lat1 = i;
    end
    for (int i = 0; i < 8; i++) chk("db_seq", seq[i], exp_seq[i]);
    chk("lat_n4", lat4, 6);
    chk("lat_n1", lat1, 3);
    chk("jog_b4", int'(if4.jogada), 4);

    // Button 4 held into the micro request: no pulse until released.
    jogar_macro = 1'b0;
    jogar_micro = 1'b1;
    p4 = pulses4;
    p1 = pulses1;
    tick(10);
    chk("held_nopulse", pulses4 - p4, 0);
    chk("held_db", int'(if4.db_estado), 1);
    botoes = 9'd0;
    tick(4);
    botoes = 9'b100000000;
    tick(12);
    chk("micro_pulse4", pulses4 - p4, 1);
    chk("micro_pulse1", pulses1 - p1, 1);
    chk("jog_b8_n4", int'(if4.jogada), 8);
    chk("jog_b8_n1", int'(if1.jogada), 8);

    // Two bits held: waits in state 2; releasing bit 0 accepts cell 1.
    jogar_micro = 1'b0;
    botoes = 9'd0;
    tick(3);
    jogar_macro = 1'b1;
    tick(3);
    p4 = pulses4;
    p1 = pulses1;
    botoes = 9'b000000011;
    tick(10);
    chk("multi_db4", int'(if4.db_estado), 2);
    chk("multi_db1", int'(if1.db_estado), 2);
    chk("multi_nopulse", (pulses4 - p4) + (pulses1 - p1), 0);
    botoes = 9'b000000010;
    tick(10);
    chk("multi_pulse4", pulses4 - p4, 1);
    chk("jog_b1", int'(if4.jogada), 1);

    // Two-cycle glitch on bit 2 is rejected with four debounce cycles.
    jogar_macro = 1'b0;
    botoes = 9'd0;
    tick(3);
    jogar_macro = 1'b1;
    tick(3);
    p4 = pulses4;
    botoes = 9'b000000100;
    tick(2);
    botoes = 9'd0;
    tick(8);
    chk("glitch_nopulse", pulses4 - p4, 0);
    chk("glitch_jog", int'(if4.jogada), 1);
    chk("glitch_db", int'(if4.db_estado), 2);

    // Enable dropped in filtra aborts the move.
    p4 = pulses4;
    botoes = 9'b000100000;
    tick(3);
    chk("abort_filtra", int'(if4.db_estado), 3);
    jogar_macro = 1'b0;
    tick();
    chk("abort_db", int'(if4.db_estado), 0);
    tick(8);
    chk("abort_nopulse", pulses4 - p4, 0);

    // zeraEdge after an accepted move clears jogada and state.
    botoes = 9'd0;
    tick(2);
    jogar_macro = 1'b1;
    tick(3);
    botoes = 9'b010000000;
    tick(12);
    chk("jog_b7", int'(if4.jogada), 7);
    zera = 1'b1;
    tick();
    zera = 1'b0;
    chk("zera_jog4", int'(if4.jogada), 0);
    chk("zera_jog1", int'(if1.jogada), 0);
    chk("zera_db", int'(if4.db_estado), 0);

    // Asynchronous reset between edges while in filtra.
    botoes = 9'd0;
    tick(4);
    botoes = 9'b001000000;
    tick(12);
    chk("jog_b6", int'(if4.jogada), 6);
    botoes = 9'd0;
    tick(4);
    botoes = 9'b000000001;
    tick(3);
    chk("pre_rst_db", int'(if4.db_estado), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_db4", int'(if4.db_estado), 0);
    chk("arst_jog4", int'(if4.jogada), 0);
    chk("arst_tem4", int'(if4.tem_jogada), 0);
    chk("arst_db1", int'(if1.db_estado), 0);
    chk("arst_jog1", int'(if1.jogada), 0);
    botoes = 9'd0;
    jogar_macro = 1'b0;
    tick(2);
    p4 = pulses4;
    p1 = pulses1;
    reset = 1'b0;
    tick(5);
    chk("arst_nopulse", (pulses4 - p4) + (pulses1 - p1), 0);

    // Randomized traffic, checked every cycle against the model.
    for (int seg = 0; seg < 700; seg++) begin
      int r;
      int hold;
      r = int'($urandom_range(99, 0));
      if (r < 40) begin
        botoes = 9'd0;
      end else if (r < 85) begin
        oh = 9'd1;
        botoes = oh << $urandom_range(8, 0);
      end else begin
        botoes = 9'($urandom);
      end
      r = int'($urandom_range(99, 0));
      jogar_macro = (r < 45);
      jogar_micro = (r >= 45 && r < 88);
      zera = ($urandom_range(99, 0) < 3);
      hold = int'($urandom_range(10, 1));
      tick();
      zera = 1'b0;
      if (hold > 1) tick(hold - 1);
    end

    jogar_macro = 1'b0;
    jogar_micro = 1'b0;
    botoes = 9'd0;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
